// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes, shared response and memory command bus for mem_arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters + memory).
interface mem_arbiter_if #(
  parameter int unsigned BLOCK_SIZE   = 32,
  parameter int unsigned ADDRESS_SIZE = 32
);
  localparam int unsigned AW = $clog2(ADDRESS_SIZE);

  logic                  a_valid_i;
  logic                  a_write_i;
  logic [AW-1:0]         a_addr_i;
  logic [BLOCK_SIZE-1:0] a_wdata_i;
  logic                  a_ready_o;
  logic                  a_rsp_valid_o;

  logic                  b_valid_i;
  logic                  b_write_i;
  logic [AW-1:0]         b_addr_i;
  logic [BLOCK_SIZE-1:0] b_wdata_i;
  logic                  b_ready_o;
  logic                  b_rsp_valid_o;

  logic [BLOCK_SIZE-1:0] rsp_data_o;
  logic                  rsp_err_o;

  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [AW-1:0]         mem_addr_o;
  logic [BLOCK_SIZE-1:0] mem_wdata_o;
  logic [BLOCK_SIZE-1:0] mem_rdata_i;

  modport slave (
    input  a_valid_i, a_write_i, a_addr_i, a_wdata_i,
    input  b_valid_i, b_write_i, b_addr_i, b_wdata_i,
    input  mem_rdata_i,
    output a_ready_o, a_rsp_valid_o, b_ready_o, b_rsp_valid_o,
    output rsp_data_o, rsp_err_o,
    output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output a_valid_i, a_write_i, a_addr_i, a_wdata_i,
    output b_valid_i, b_write_i, b_addr_i, b_wdata_i,
    output mem_rdata_i,
    input  a_ready_o, a_rsp_valid_o, b_ready_o, b_rsp_valid_o,
    input  rsp_data_o, rsp_err_o,
    input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-port scratch memory.
// One request in flight: IDLE grants, CMD strobes the memory, RESP returns read data.
module mem_arbiter #(
  parameter int unsigned BLOCK_SIZE   = 32,
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DEPTH        = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_arbiter_if.slave   bus
);
  localparam int unsigned AW = $clog2(ADDRESS_SIZE);

  typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

  state_e                state_q, state_d;
  logic                  last_b_q, last_b_d;  // 1: B held the most recent grant
  logic                  port_b_q, port_b_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [BLOCK_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [BLOCK_SIZE-1:0] rsp_data_q, rsp_data_d;

  logic                  sel_b, grant_a, grant_b, in_range, req_write, rsp_fire;
  logic [AW-1:0]         req_addr;
  logic [BLOCK_SIZE-1:0] req_wdata;

  always_comb begin
    sel_b     = bus.b_valid_i && (!bus.a_valid_i || !last_b_q);
    grant_a   = (state_q == StIdle) && bus.a_valid_i && !sel_b;
    grant_b   = (state_q == StIdle) && sel_b;
    req_write = sel_b ? bus.b_write_i : bus.a_write_i;
    req_addr  = sel_b ? bus.b_addr_i  : bus.a_addr_i;
    req_wdata = sel_b ? bus.b_wdata_i : bus.a_wdata_i;
    in_range  = 32'(req_addr) < DEPTH;

    state_d     = state_q;
    last_b_d    = last_b_q;
    port_b_d    = port_b_q;
    write_d     = write_q;
    err_d       = err_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (grant_a || grant_b) begin
          state_d  = StCmd;
          last_b_d = sel_b;
          port_b_d = sel_b;
          write_d  = req_write;
          err_d    = !in_range;
          // Out-of-range requests never reach the memory bus, not even the address.
          if (in_range) begin
            mem_read_d  = !req_write;
            mem_write_d = req_write;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end
        end
      end
      StCmd: begin
        state_d = (write_q || err_q) ? StIdle : StResp;
        if (err_q) rsp_data_d = '0;
      end
      StResp: begin
        state_d    = StIdle;
        rsp_data_d = bus.mem_rdata_i;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      last_b_q    <= 1'b1;
      port_b_q    <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      port_b_q    <= port_b_d;
      write_q     <= write_d;
      err_q       <= err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Handshake and response outputs are masked during reset so a dropped request never responds.
  assign rsp_fire = !rst_i && (((state_q == StCmd) && (write_q || err_q)) || (state_q == StResp));

  assign bus.a_ready_o     = !rst_i && grant_a;
  assign bus.b_ready_o     = !rst_i && grant_b;
  assign bus.a_rsp_valid_o = rsp_fire && !port_b_q;
  assign bus.b_rsp_valid_o = rsp_fire && port_b_q;
  assign bus.rsp_err_o     = !rst_i && (state_q == StCmd) && err_q;
  assign bus.rsp_data_o    = (state_q == StResp)           ? bus.mem_rdata_i :
                             ((state_q == StCmd) && err_q) ? '0 : rsp_data_q;
  assign bus.mem_read_o    = mem_read_q;
  assign bus.mem_write_o   = mem_write_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_wdata_o   = mem_wdata_q;
endmodule
